// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and parameter defaults shared by the fetch controller files.
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } state_e;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_RESET_PC = 0;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: loader, memory, redirect/halt and decode handshake signals of the fetch controller.
interface fetch_if #(parameter int ADDR_W = fetch_pkg::DEF_ADDR_W);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              halt;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr;
  logic              out_ready;
  logic [1:0]        state;
  modport master (
    input  ld_valid, ld_addr, ld_data, ld_done, mem_rdata, redir_valid, redir_pc, halt, out_ready,
    output mem_addr, mem_we, mem_wdata, out_valid, out_pc, out_instr, state
  );
  modport slave (
    output ld_valid, ld_addr, ld_data, ld_done, mem_rdata, redir_valid, redir_pc, halt, out_ready,
    input  mem_addr, mem_we, mem_wdata, out_valid, out_pc, out_instr, state
  );
endinterface

// File: rtl/fetch_mem_mux.sv
// fetch_mem_mux: selects loader or fetch access to the instruction memory; loader path only with FETCH_LOADER_EN.
module fetch_mem_mux #(
  parameter int ADDR_W = fetch_pkg::DEF_ADDR_W
) (
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [31:0]       i_ld_data,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata
);
`ifdef FETCH_LOADER_EN
  assign o_mem_addr  = !i_rst_n ? '0 : i_load ? i_ld_addr : i_fetch_addr;
  assign o_mem_we    = i_rst_n && i_load && i_ld_valid;
  assign o_mem_wdata = (i_rst_n && i_load) ? i_ld_data : '0;
`else
  logic w_unused;
  assign w_unused    = ^{i_load, i_ld_valid, i_ld_addr, i_ld_data};
  assign o_mem_addr  = i_rst_n ? i_fetch_addr : '0;
  assign o_mem_we    = 1'b0;
  assign o_mem_wdata = '0;
`endif
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM with redirect, halt and decode handshake; FETCH_LOADER_EN adds the LOAD phase.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);
`ifdef FETCH_LOADER_EN
  localparam state_e ST_INIT = ST_LOAD;
`else
  localparam state_e ST_INIT = ST_RUN;
  logic w_unused;
  assign w_unused = bus.ld_done;
`endif
  state_e            r_state, w_nstate;
  logic [ADDR_W-1:0] r_pc, w_npc, r_out_pc, w_nout_pc, w_fetch_addr;
  logic              r_pend, w_npend, w_accept;
  assign w_accept     = !r_pend || bus.out_ready;
  // A stalled output re-reads its own word so out_instr stays stable.
  assign w_fetch_addr = (r_pend && !bus.out_ready) ? r_out_pc : r_pc;
  always_comb begin
    w_nstate  = r_state;
    w_npc     = r_pc;
    w_npend   = r_pend;
    w_nout_pc = r_out_pc;
    case (r_state)
`ifdef FETCH_LOADER_EN
      ST_LOAD: if (bus.ld_done) begin
        w_nstate = ST_RUN;
        w_npc    = PC0;
      end
`else
      ST_LOAD: w_nstate = ST_RUN;
`endif
      ST_RUN: if (bus.halt) begin
        w_npend  = r_pend && !bus.out_ready;
        w_nstate = w_accept ? ST_HALT : ST_RUN;
      end else if (bus.redir_valid) begin
        w_npend  = 1'b0;
        w_npc    = bus.redir_pc;
        w_nstate = ST_FLUSH;
      end else if (w_accept) begin
        w_npend   = 1'b1;
        w_nout_pc = r_pc;
        w_npc     = r_pc + 1'b1;
      end
      ST_FLUSH: if (bus.redir_valid) begin
        w_npc = bus.redir_pc;
      end else begin
        w_npend   = 1'b1;
        w_nout_pc = r_pc;
        w_npc     = r_pc + 1'b1;
        w_nstate  = ST_RUN;
      end
      default: w_npend = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_INIT;
      r_pc     <= PC0;
      r_pend   <= 1'b0;
      r_out_pc <= '0;
    end else begin
      r_state  <= w_nstate;
      r_pc     <= w_npc;
      r_pend   <= w_npend;
      r_out_pc <= w_nout_pc;
    end
  end
  fetch_mem_mux #(.ADDR_W(ADDR_W)) u_mux (
    .i_rst_n      (rst),
    .i_load       (r_state == ST_LOAD),
    .i_ld_valid   (bus.ld_valid),
    .i_ld_addr    (bus.ld_addr),
    .i_ld_data    (bus.ld_data),
    .i_fetch_addr (w_fetch_addr),
    .o_mem_addr   (bus.mem_addr),
    .o_mem_we     (bus.mem_we),
    .o_mem_wdata  (bus.mem_wdata)
  );
  assign bus.out_valid = r_pend;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_instr = bus.mem_rdata;
  assign bus.state     = r_state;
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, which sets the instruction word-address width (256 words).
REQ-002 SHALL have parameter RESET_PC, default 0, which sets the first word address fetched after load.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have loader ports, all inputs: ld_valid (1), ld_addr (ADDR_W), ld_data (32), ld_done (1).
REQ-006 SHALL have memory ports: mem_addr out ADDR_W, mem_we out 1, mem_wdata out 32, and mem_rdata in 32; mem_rdata is the word at the previous cycle's mem_addr.
REQ-007 SHALL have redirect inputs: redir_valid (1) and redir_pc (ADDR_W).
REQ-008 SHALL have input halt, 1 bit.
REQ-009 SHALL have decode handshake ports: out_valid out 1, out_pc out ADDR_W, out_instr out 32, and out_ready in 1.
REQ-010 SHALL have output state, 2 bits: LOAD=00, RUN=01, FLUSH=10, HALT=11.

Function
REQ-011 LOAD SHALL drive mem_addr=ld_addr, mem_we=ld_valid and mem_wdata=ld_data, and hold out_valid=0.
REQ-012 ld_done in LOAD SHALL set fetch_pc=RESET_PC and move to RUN on the next edge; a same-cycle ld_valid write SHALL still complete.
REQ-013 In RUN, FLUSH and HALT, mem_we SHALL be 0.
REQ-014 In RUN, mem_addr SHALL equal fetch_pc whenever the output slot is empty or accepted (out_ready=1), and fetch_pc SHALL then increment by 1.
REQ-015 A RUN issue SHALL set a pending flag, so that next cycle out_valid=1, out_pc=issued address and out_instr=mem_rdata (latency 1).
REQ-016 On out_valid=1 with out_ready=0, mem_addr SHALL equal out_pc and fetch_pc SHALL hold, so out_pc and out_instr stay stable until accepted.
REQ-017 fetch_pc SHALL wrap from 2^ADDR_W-1 to 0.
REQ-018 redir_valid in RUN SHALL discard the in-flight read, set fetch_pc=redir_pc and enter FLUSH; out_valid SHALL be 0 in the following cycle.
REQ-019 FLUSH SHALL last exactly one cycle: issue fetch_pc, increment it and return to RUN, so redir_pc's instruction is valid 2 cycles after redir_valid.
REQ-020 redir_valid in FLUSH SHALL restart FLUSH with the new redir_pc.
REQ-021 halt in RUN SHALL stop issuing; the state SHALL become HALT once no valid output is pending or it is accepted.
REQ-022 halt and redir_valid in the same cycle SHALL give halt priority and ignore the redirect.
REQ-023 HALT SHALL be left only by reset, with out_valid=0 throughout.
REQ-024 ld_* inputs SHALL be ignored outside LOAD.

Reset
REQ-025 rst=0 SHALL immediately force state=LOAD, fetch_pc=RESET_PC, pending=0, out_valid=0, out_pc=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-026 Reset mid-fetch or mid-load SHALL discard all in-flight reads without emitting them.

Configuration
REQ-027 With macro FETCH_LOADER_EN defined, the LOAD state and loader path SHALL be present as specified.
REQ-028 Without FETCH_LOADER_EN, reset SHALL exit directly to RUN, ld_* inputs SHALL be ignored and mem_we SHALL be constant 0; the ports SHALL remain present.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state encoding constants and the ADDR_W and RESET_PC defaults.
REQ-030 Memory-port muxing (loader vs fetch) SHALL be the sub-module fetch_mem_mux; FSM, PC and pending logic SHALL stay in fetch_ctrl.

Verification
REQ-031 Load words 0..3 = 0x11,0x22,0x33,0x44, then ld_done, out_ready=1 -> out_valid rises 2 cycles after ld_done; pc/instr = 0/0x11, 1/0x22, 2/0x33, 3/0x44 on consecutive cycles.
REQ-032 Hold out_ready=0 for 3 cycles at pc=1 -> out_pc=1 and out_instr=0x22 stable; mem_addr=1; pc=2 follows the cycle after out_ready=1.
REQ-033 redir_valid with redir_pc=0x80 while pc=2 is valid -> one out_valid=0 cycle, then pc=0x80 with RAM[0x80]; pc=3 never appears.
REQ-034 Start at RESET_PC=0xFE -> pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-035 halt together with redir_valid -> no redirect; HALT entered once the pending instruction is accepted; out_valid stays 0 for 10 cycles.
REQ-036 Assert rst=0 mid-stream (and mid-load) -> same-cycle out_valid=0, mem_we=0, state=LOAD; with FETCH_LOADER_EN undefined, state=RUN and pc=RESET_PC is issued after release.
